// File: rtl/bios_arb_pkg.sv
// Shared types and default widths for the BIOS ROM arbiter.
package bios_arb_pkg;

    localparam int unsigned AW_DEF = 16;
    localparam int unsigned DW_DEF = 16;

    // Transaction sequencer states: one grant cycle, one ROM cycle, one ack cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin decision: a lone requester wins; on contention the
// requester that did not win last time is chosen.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    // Combinational winner selection.
    always_comb begin
        grant_valid = |req;
        grant_idx   = 1'b0;
        case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_grant;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/bios_arbiter.sv
// Arbitrates instruction-fetch (m0) and data (m1) reads onto a single BIOS ROM.
// Every access takes three cycles: grant, ROM access, one-cycle ack.
module bios_arbiter
    import bios_arb_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic [1:0]    m0_be,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic [1:0]    m1_be,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] rom_addr,
    output logic [1:0]    rom_be,
    output logic          rom_ce,
    input  logic [DW-1:0] rom_data
);

    state_e        state_q,      state_d;
    logic          last_grant_q, last_grant_d;
    logic          gnt_idx_q,    gnt_idx_d;
    logic [AW-1:0] gnt_addr_q,   gnt_addr_d;
    logic [1:0]    gnt_be_q,     gnt_be_d;
    logic          rom_ce_q,     rom_ce_d;
    logic          m0_ack_q,     m0_ack_d;
    logic          m1_ack_q,     m1_ack_d;
    logic [DW-1:0] m0_rdata_q,   m0_rdata_d;
    logic [DW-1:0] m1_rdata_q,   m1_rdata_d;

    logic          grant_valid_s;
    logic          grant_idx_s;

    rr_arb2 u_rr_arb2 (
        .req         ({m1_req, m0_req}),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid_s),
        .grant_idx   (grant_idx_s)
    );

    // Next-state and next-output logic; everything holds unless a state acts on it.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_idx_d    = gnt_idx_q;
        gnt_addr_d   = gnt_addr_q;
        gnt_be_d     = gnt_be_q;
        rom_ce_d     = 1'b0;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_valid_s) begin
                    state_d      = ACCESS;
                    last_grant_d = grant_idx_s;
                    gnt_idx_d    = grant_idx_s;
                    gnt_addr_d   = grant_idx_s ? m1_addr : m0_addr;
                    gnt_be_d     = grant_idx_s ? m1_be   : m0_be;
                    rom_ce_d     = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                // ROM data is combinational; capture it at the end of the access cycle.
                state_d = RESP;
                if (gnt_idx_q) begin
                    m1_rdata_d = rom_data;
                    m1_ack_d   = 1'b1;
                end else begin
                    m0_rdata_d = rom_data;
                    m0_ack_d   = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_idx_q    <= 1'b0;
            gnt_addr_q   <= {AW{1'b0}};
            gnt_be_q     <= 2'b00;
            rom_ce_q     <= 1'b0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_rdata_q   <= {DW{1'b0}};
            m1_rdata_q   <= {DW{1'b0}};
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_idx_q    <= gnt_idx_d;
            gnt_addr_q   <= gnt_addr_d;
            gnt_be_q     <= gnt_be_d;
            rom_ce_q     <= rom_ce_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    // ROM address/be come straight from the grant registers, so they hold when idle.
    assign rom_addr = gnt_addr_q;
    assign rom_be   = gnt_be_q;
    assign rom_ce   = rom_ce_q;
    assign m0_ack   = m0_ack_q;
    assign m1_ack   = m1_ack_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;

endmodule
